// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter with registered one-hot grant and a bounded
// hold: a contended owner is rotated out after MAX_HOLD cycles of grant.
module rr_arbiter4 #(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] gnt_id,
    output logic       busy
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t           st_q;
    logic [1:0]       owner_q;
    logic [1:0]       ptr_q;
    logic [CNT_W-1:0] hold_q;
    logic [CNT_W-1:0] hold_d;
    logic [3:0]       gnt_q;
    logic             busy_q;

    logic [3:0] cand;
    logic [7:0] cand_dbl;
    logic [3:0] rot;
    logic [1:0] idx;
    logic [1:0] win;
    logic       any_cand;
    logic       owner_req;
    logic       hold_max;
    logic       keep;

    // While granted, only the other requesters compete; the owner is excluded so a
    // preemption always lands on someone else.
    assign cand      = (st_q == GRANT) ? (req & ~gnt_q) : req;
    assign cand_dbl  = {cand, cand};
    assign rot       = cand_dbl[ptr_q +: 4];
    assign any_cand  = |cand;

    assign idx[0]    = ~rot[0] & (rot[1] | ~rot[2]);
    assign idx[1]    = ~rot[0] & ~rot[1];
    assign win       = ptr_q + idx;

    assign owner_req = |(req & gnt_q);
    assign hold_max  = (hold_q == CNT_W'(MAX_HOLD - 1));
    assign hold_d    = hold_max ? hold_q : hold_q + 1'b1;
    assign keep      = (st_q == GRANT) && owner_req && !(any_cand && hold_max);

    // NOTE: every state and output register is updated with <= in this one clocked
    // block, so all of them see the same pre-edge values of each other.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            st_q    <= IDLE;
            owner_q <= 2'd0;
            ptr_q   <= 2'd0;
            hold_q  <= '0;
            gnt_q   <= 4'b0000;
            busy_q  <= 1'b0;
        end else if (keep) begin
            hold_q <= hold_d;
        end else if (any_cand) begin
            st_q    <= GRANT;
            owner_q <= win;
            ptr_q   <= win + 2'd1;
            hold_q  <= '0;
            gnt_q   <= 4'b0001 << win;
            busy_q  <= 1'b1;
        end else begin
            st_q    <= IDLE;
            owner_q <= 2'd0;
            hold_q  <= '0;
            gnt_q   <= 4'b0000;
            busy_q  <= 1'b0;
        end
    end

    assign gnt    = gnt_q;
    assign gnt_id = owner_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_rr_arbiter4.sv
// Directed bench for rr_arbiter4: a queue-free round-robin model checked every cycle,
// plus literal expectations for reset, contention, handoff, saturation and wrap.
module tb_rr_arbiter4;

    localparam int MAX_HOLD = 8;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic [3:0] req = 4'b0000;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       busy;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    rr_arbiter4 #(.MAX_HOLD(MAX_HOLD), .CNT_W(4)) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .req    (req),
        .gnt    (gnt),
        .gnt_id (gnt_id),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Model: owner = -1 when idle, held = grant cycles already given to owner,
    // start = where the next round-robin scan begins.
    typedef struct {
        int owner;
        int held;
        int start;
    } mstate_t;

    mstate_t m;

    function automatic mstate_t model_step(mstate_t s, logic [3:0] r);
        mstate_t n = s;
        logic [3:0] others = r;
        if (s.owner >= 0) others[s.owner] = 1'b0;
        if (s.owner >= 0 && r[s.owner] && (others == 4'b0000 || s.held < MAX_HOLD)) begin
            n.held = s.held + 1;
        end else if (others != 4'b0000) begin
            for (int k = 0; k < 4; k++) begin
                if (others[(s.start + k) % 4]) begin
                    n.owner = (s.start + k) % 4;
                    break;
                end
            end
            n.held  = 1;
            n.start = (n.owner + 1) % 4;
        end else begin
            n.owner = -1;
            n.held  = 0;
        end
        return n;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) m <= '{owner: -1, held: 0, start: 0};
        else          m <= model_step(m, req);
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_gnt", {4'b0, gnt}, (m.owner < 0) ? 8'h00 : 8'(1 << m.owner));
            check("model_gnt_id", {6'b0, gnt_id}, (m.owner < 0) ? 8'h00 : 8'(m.owner));
            check("model_busy", {7'b0, busy}, (m.owner < 0) ? 8'h00 : 8'h01);
        end
    end

    task automatic tick;
        @(negedge clk);
    endtask

    initial begin
        // Reset asserted with all requests high, before any clock edge.
        req = 4'b1111;
        #1 reset_n = 1'b0;
        #2;
        check("rst_gnt", {4'b0, gnt}, 8'h00);
        check("rst_gnt_id", {6'b0, gnt_id}, 8'h00);
        check("rst_busy", {7'b0, busy}, 8'h00);
        tick; tick;
        check("rst_hold_gnt", {4'b0, gnt}, 8'h00);
        reset_n = 1'b1;
        chk_en = 1'b1;

        // Full contention: each owner gets exactly MAX_HOLD cycles, in order 0,1,2,3,0.
        for (int n = 1; n <= 40; n++) begin
            tick;
            check("contend_gnt", {4'b0, gnt}, 8'(1 << (((n - 1) / MAX_HOLD) % 4)));
        end
        req = 4'b0000;
        tick;
        check("contend_idle", {4'b0, gnt}, 8'h00);

        // Single requester 2 for three edges, then drop.
        req = 4'b0100;
        for (int n = 0; n < 3; n++) begin
            tick;
            check("single_gnt", {4'b0, gnt}, 8'h04);
            check("single_id", {6'b0, gnt_id}, 8'h02);
            check("single_busy", {7'b0, busy}, 8'h01);
        end
        req = 4'b0000;
        tick;
        check("single_drop", {4'b0, gnt}, 8'h00);

        // Release handoff 0 -> 3 without a bubble.
        req = 4'b0001;
        tick;
        check("handoff_own0", {4'b0, gnt}, 8'h01);
        req = 4'b1001;
        tick; tick;
        check("handoff_still0", {4'b0, gnt}, 8'h01);
        req = 4'b1000;
        tick;
        check("handoff_gnt", {4'b0, gnt}, 8'h08);
        check("handoff_id", {6'b0, gnt_id}, 8'h03);
        req = 4'b0000;
        tick;

        // Uncontended owner 1 for 20 cycles; hold counter saturates at MAX_HOLD-1.
        req = 4'b0010;
        for (int n = 0; n < 20; n++) begin
            tick;
            check("uncont_gnt", {4'b0, gnt}, 8'h02);
        end
        check("uncont_sat", 8'(dut.hold_q), 8'(MAX_HOLD - 1));

        // Contention arriving after saturation preempts at the next edge; scan 2,3,0 finds 0.
        req = 4'b0011;
        tick;
        check("sat_preempt", {4'b0, gnt}, 8'h01);

        // Simultaneous release of 0 and new request from 2.
        req = 4'b0100;
        tick;
        check("simul_gnt", {4'b0, gnt}, 8'h04);
        check("simul_id", {6'b0, gnt_id}, 8'h02);

        // Reset pulse mid-grant with owner 2 and all requesting.
        req = 4'b1111;
        tick; tick;
        check("mid_owner2", {4'b0, gnt}, 8'h04);
        #2 reset_n = 1'b0;
        #1;
        check("mid_rst_gnt", {4'b0, gnt}, 8'h00);
        check("mid_rst_id", {6'b0, gnt_id}, 8'h00);
        check("mid_rst_busy", {7'b0, busy}, 8'h00);
        tick;
        reset_n = 1'b1;
        tick;
        check("post_rst_gnt", {4'b0, gnt}, 8'h01);

        // A few more cycles of mixed traffic under the model.
        req = 4'b1010;
        repeat (12) tick;
        req = 4'b0000;
        repeat (2) tick;

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout at %0t: bench did not complete, expected finish", $time);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/rr_arbiter4.md
# rr_arbiter4

- Four-requester round-robin arbiter with bounded grant hold.
- Shares one resource (a shared ALU or bus port built from the team's primitive gate library) among four requesters.
- Grants are registered one-hot, held for as long as the owner keeps requesting, and forcibly rotated after MAX_HOLD cycles when another requester is waiting.
- Sits between requester FSMs and the shared datapath's operand/select muxes; gnt drives the mux selects directly.

## Interface
- MAX_HOLD, 8, maximum consecutive grant cycles for one owner while others wait; legal range 1..15.
- CNT_W, 4, hold counter width; must satisfy 2^CNT_W > MAX_HOLD.
- clk  input  1  rising-edge clock.
- reset_n  input  1  reset, asynchronous, active-low.
- req  input  4  request vector; bit i high = requester i wants the resource.
- gnt  output  4  registered one-hot grant; all-zero when idle.
- gnt_id  output  2  binary index of the current owner; 0 when idle.
- busy  output  1  high whenever gnt is non-zero.

## Operation
- Only clk and reset_n are used: one clock, asynchronous active-low reset.
- State: st ∈ {IDLE, GRANT}, owner[1:0], ptr[1:0] (priority pointer), hold_cnt[CNT_W-1:0].
- Reset (reset_n=0, immediate, no clock needed): st=IDLE, gnt=0000, gnt_id=0, busy=0, ptr=0, hold_cnt=0.
- Winner search, combinational: first i with req[i]=1, scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4).
- IDLE:
  - If req≠0: go to GRANT; owner=winner; gnt=onehot(winner); ptr=winner+1 (mod 4); hold_cnt=0.
  - If req=0: stay in IDLE.
- GRANT, evaluated each edge. Let others = req with the owner bit masked.
  - req[owner]=0 and others≠0: hand off directly to the winner. The search starts at ptr, which is owner+1. There is no idle bubble; hold_cnt=0 and ptr=new winner+1.
  - req[owner]=0 and others=0: go to IDLE and drive all outputs to 0.
  - req[owner]=1, others≠0, and hold_cnt=MAX_HOLD-1: preempt and hand off as above.
  - req[owner]=1 otherwise: keep the grant; hold_cnt increments and saturates at MAX_HOLD-1.
- Hold rules:
  - hold_cnt counts cycles during which gnt has been asserted to the current owner, minus one.
  - A contended owner therefore sees exactly MAX_HOLD cycles of gnt.
  - An uncontended owner keeps the grant indefinitely.
- A requester must not assume the grant persists after it drops req. A preempted requester stays in the queue if it keeps req high and is served again in round-robin order.
- gnt is never more than one-hot. Outputs come only from registers, with no combinational path from req.
- Priority logic is built from primitive gates. The only storage is edge-triggered flops with async clear.

## Timing
- Grant latency: req rising before edge k gives gnt valid after edge k (1 cycle) when idle.
- Release latency: req[owner] falling before edge k gives gnt change after edge k.
- Handoff is zero-bubble: the old grant and the new grant occupy adjacent cycles.
- Simultaneous release and new request in the same cycle: the new request is considered at that edge.
- Preemption with MAX_HOLD=1: the grant rotates every cycle under contention.
- ptr wrap: 3+1 → 0.
- Reset mid-grant: gnt drops asynchronously when reset_n falls. The first grant after reset_n rises uses ptr=0.
- Requests arriving during reset are ignored. They are sampled at the first clk edge after reset_n=1.

## Test plan
- Reset: assert reset_n=0 with req=1111 → gnt=0000, gnt_id=0, busy=0, with no clk edge needed.
- Single requester: req=0100 held 3 cycles, then 0000 → gnt=0100, gnt_id=2, busy=1 for 3 cycles starting one edge after req; gnt=0000 one edge after the drop.
- Full contention: MAX_HOLD=8, req=1111 held from reset → gnt sequence 0001, 0010, 0100, 1000, 0001, each lasting exactly 8 cycles, with no idle cycles between.
- Release handoff: req=1001, owner 0, then req[0] drops at cycle t → gnt=1000 after edge t, gnt_id=3, with no 0000 cycle.
- Uncontended hold: req=0010 held 20 cycles, MAX_HOLD=8 → gnt=0010 for all 20 cycles and hold_cnt saturates at 7.
- Reset mid-operation: owner 2 with req=1111, pulse reset_n low between edges → gnt=0000 immediately. After release, first grant is 0001 because ptr=0.
